// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and index width
//   ZERO_IDX                        : index of the hardwired-zero register
//   is_writable()                   : 0 only for the hardwired-zero index when enabled
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned ZERO_IDX       = 0;

    // Index is passed zero-extended to 32 bits so any ADDR_W can share this helper.
    function automatic logic is_writable(input logic [31:0] idx, input logic zeroReg);
        return !(zeroReg && (idx == ZERO_IDX));
    endfunction

endpackage

// File: rtl/regfile_sb_bits.sv
// Busy-bit scoreboard: one busy bit per register plus a registered busy count.
//   clock, reset  : posedge clock, synchronous active-high reset
//   setEn, setIdx : issue (already qualified as writable) marks setIdx busy
//   clrEn, clrIdx : writeback (already qualified as writable) clears clrIdx
//   busy          : current busy vector
//   busyCount     : number of set bits in busy, tracked incrementally
module regfile_sb_bits
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                setEn,
    input  logic [ADDR_W-1:0]   setIdx,
    input  logic                clrEn,
    input  logic [ADDR_W-1:0]   clrIdx,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     busyCount
);

    logic [NUM_REGS-1:0] busyQ, busyD;
    logic [ADDR_W:0]     countQ, countD;
    logic                incr, decr;

    always_comb begin
        busyD = busyQ;
        // Set applied after clear: a new producer wins over a same-index writeback.
        if (clrEn) busyD[clrIdx] = 1'b0;
        if (setEn) busyD[setIdx] = 1'b1;

        incr = setEn && !busyQ[setIdx];
        decr = clrEn && busyQ[clrIdx] && !(setEn && (setIdx == clrIdx));

        countD = countQ;
        if (incr && !decr) begin
            countD = countQ + (ADDR_W + 1)'(1);
        end else if (decr && !incr) begin
            countD = countQ - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busyQ  <= '0;
            countQ <= '0;
        end else begin
            busyQ  <= busyD;
            countQ <= countD;
        end
    end

    assign busy      = busyQ;
    assign busyCount = countQ;

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with same-cycle write->read bypass and a per-register
// busy scoreboard for decode stall detection.
//   clock, ctrl_reset                     : posedge clock, synchronous active-high reset
//   ctrl_writeEnable/Reg, data_writeReg   : writeback port (also clears busy)
//   ctrl_issueEnable, ctrl_issueReg       : issue port (marks destination busy)
//   ctrl_readRegA/B -> data_readRegA/B    : combinational read ports
//   busy_readRegA/B                       : source has an outstanding producer
//   busy_count, any_busy                  : registered busy population / nonzero flag
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic              ctrl_issueEnable,
    input  logic [ADDR_W-1:0] ctrl_issueReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              busy_readRegA,
    output logic              busy_readRegB,
    output logic [ADDR_W:0]   busy_count,
    output logic              any_busy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic        ZeroEn   = (ZERO_REG != 0);
    localparam logic        BypassEn = (BYPASS != 0);

    logic [DATA_W-1:0]   regsQ [NUM_REGS];
    logic [NUM_REGS-1:0] busyVec;
    logic                writeOk, issueOk;
    logic                fwdA, fwdB;

    assign writeOk = ctrl_writeEnable && is_writable(32'(ctrl_writeReg), ZeroEn);
    assign issueOk = ctrl_issueEnable && is_writable(32'(ctrl_issueReg), ZeroEn);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regsQ[i] <= '0;
            end
        end else if (writeOk) begin
            regsQ[ctrl_writeReg] <= data_writeReg;
        end
    end

    regfile_sb_bits #(
        .ADDR_W (ADDR_W)
    ) u_sbBits (
        .clock     (clock),
        .reset     (ctrl_reset),
        .setEn     (issueOk),
        .setIdx    (ctrl_issueReg),
        .clrEn     (writeOk),
        .clrIdx    (ctrl_writeReg),
        .busy      (busyVec),
        .busyCount (busy_count)
    );

    assign fwdA = BypassEn && writeOk && (ctrl_writeReg == ctrl_readRegA);
    assign fwdB = BypassEn && writeOk && (ctrl_writeReg == ctrl_readRegB);

    always_comb begin
        data_readRegA = regsQ[ctrl_readRegA];
        data_readRegB = regsQ[ctrl_readRegB];
        if (fwdA) data_readRegA = data_writeReg;
        if (fwdB) data_readRegB = data_writeReg;
        // Zero index is never written, but force it so the read path does not depend on that.
        if (ZeroEn && (ctrl_readRegA == ADDR_W'(ZERO_IDX))) data_readRegA = '0;
        if (ZeroEn && (ctrl_readRegB == ADDR_W'(ZERO_IDX))) data_readRegB = '0;
    end

    // A forwarded value is final, so the consumer need not stall on it.
    assign busy_readRegA = busyVec[ctrl_readRegA] && !fwdA;
    assign busy_readRegB = busyVec[ctrl_readRegB] && !fwdB;
    assign any_busy      = (busy_count != '0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing instance and one non-bypassing instance share stimulus.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;

    logic [31:0] dataA, dataB, dataA0, dataB0;
    logic        busyA, busyB, busyA0, busyB0;
    logic [5:0]  cnt, cnt0;
    logic        anyB, anyB0;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(
        .DATA_W (32), .ADDR_W (5), .ZERO_REG (1), .BYPASS (1)
    ) dutByp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (dataA),
        .data_readRegB    (dataB),
        .busy_readRegA    (busyA),
        .busy_readRegB    (busyB),
        .busy_count       (cnt),
        .any_busy         (anyB)
    );

    regfile_scoreboard #(
        .DATA_W (32), .ADDR_W (5), .ZERO_REG (1), .BYPASS (0)
    ) dutNoByp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (dataA0),
        .data_readRegB    (dataB0),
        .busy_readRegA    (busyA0),
        .busy_readRegB    (busyB0),
        .busy_count       (cnt0),
        .any_busy         (anyB0)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] expA;
        logic [31:0] expB;
        logic        expBA;
        logic        expBB;
        logic [5:0]  expCnt;
        logic [31:0] expA0;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic ie, input logic [4:0] ir,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] expA, input logic [31:0] expB,
                                input logic expBA, input logic expBB, input logic [5:0] expCnt,
                                input logic [31:0] expA0);
        vec_t v;
        v.rst = rst; v.we = we; v.wr = wr; v.wd = wd; v.ie = ie; v.ir = ir;
        v.ra = ra; v.rb = rb; v.expA = expA; v.expB = expB; v.expBA = expBA;
        v.expBB = expBB; v.expCnt = expCnt; v.expA0 = expA0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ctrl_reset       = v.rst;
        ctrl_writeEnable = v.we;
        ctrl_writeReg    = v.wr;
        data_writeReg    = v.wd;
        ctrl_issueEnable = v.ie;
        ctrl_issueReg    = v.ir;
        ctrl_readRegA    = v.ra;
        ctrl_readRegB    = v.rb;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write/bypass, zero register, issue/writeback, same-cycle issue+write, reset priority.
        vecs[0]  = mk(0, 1,  5, DB,           0, 0,  5,  0, DB,    0,     0, 0, 0, 0);
        vecs[1]  = mk(0, 0,  0, 0,            0, 0,  5,  5, DB,    DB,    0, 0, 0, DB);
        vecs[2]  = mk(0, 1,  0, 32'h12345678, 1, 0,  0,  0, 0,     0,     0, 0, 0, 0);
        vecs[3]  = mk(0, 0,  0, 0,            0, 0,  0,  0, 0,     0,     0, 0, 0, 0);
        vecs[4]  = mk(0, 0,  0, 0,            1, 7,  7,  7, 0,     0,     0, 0, 0, 0);
        vecs[5]  = mk(0, 0,  0, 0,            0, 0,  7,  7, 0,     0,     1, 1, 1, 0);
        vecs[6]  = mk(0, 0,  0, 0,            0, 0,  7,  7, 0,     0,     1, 1, 1, 0);
        vecs[7]  = mk(0, 0,  0, 0,            0, 0,  7,  7, 0,     0,     1, 1, 1, 0);
        vecs[8]  = mk(0, 1,  7, 32'hA5,       0, 0,  7,  7, 'hA5,  'hA5,  0, 0, 1, 0);
        vecs[9]  = mk(0, 0,  0, 0,            0, 0,  7,  5, 'hA5,  DB,    0, 0, 0, 'hA5);
        vecs[10] = mk(0, 1,  9, 32'h55,       1, 9,  9,  9, 'h55,  'h55,  0, 0, 0, 0);
        vecs[11] = mk(0, 0,  0, 0,            0, 0,  9,  3, 'h55,  0,     1, 0, 1, 'h55);
        vecs[12] = mk(0, 1,  9, 32'h66,       1, 3,  3,  9, 0,     'h66,  0, 0, 1, 0);
        vecs[13] = mk(0, 0,  0, 0,            0, 0,  3,  9, 0,     'h66,  1, 0, 1, 0);
        vecs[14] = mk(0, 1, 10, 32'h77,       1, 1, 10,  1, 'h77,  0,     0, 0, 1, 0);
        vecs[15] = mk(0, 0,  0, 0,            1, 2,  1,  2, 0,     0,     1, 0, 2, 0);
        vecs[16] = mk(0, 0,  0, 0,            1, 3,  3, 10, 0,     'h77,  1, 0, 3, 0);
        vecs[17] = mk(0, 0,  0, 0,            1, 4,  4,  2, 0,     0,     0, 1, 3, 0);
        vecs[18] = mk(1, 1,  2, 32'h99,       1, 5,  4, 10, 0,     'h77,  1, 0, 4, 0);
        vecs[19] = mk(0, 0,  0, 0,            0, 0, 10,  2, 0,     0,     0, 0, 0, 0);
        vecs[20] = mk(0, 0,  0, 0,            0, 0,  4,  1, 0,     0,     0, 0, 0, 0);
        vecs[21] = mk(0, 0,  0, 0,            0, 0,  5,  9, 0,     0,     0, 0, 0, 0);

        // Reset with a conflicting write and issue pending; reset must win.
        drive(mk(1, 1, 3, 32'hFFFF_FFFF, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        drive(idle);

        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #2;
            check($sformatf("reset dataA r%0d", i), dataA, 32'h0);
            check($sformatf("reset dataB r%0d", 31 - i), dataB, 32'h0);
            check($sformatf("reset busyA r%0d", i), 32'(busyA), 32'h0);
            check($sformatf("reset busyB r%0d", 31 - i), 32'(busyB), 32'h0);
            @(negedge clock);
        end
        check("reset busy_count", 32'(cnt), 32'h0);
        check("reset any_busy", 32'(anyB), 32'h0);

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v]);
            #2;
            check($sformatf("vec%0d dataA", v), dataA, vecs[v].expA);
            check($sformatf("vec%0d dataB", v), dataB, vecs[v].expB);
            check($sformatf("vec%0d busyA", v), 32'(busyA), 32'(vecs[v].expBA));
            check($sformatf("vec%0d busyB", v), 32'(busyB), 32'(vecs[v].expBB));
            check($sformatf("vec%0d busy_count", v), 32'(cnt), 32'(vecs[v].expCnt));
            check($sformatf("vec%0d any_busy", v), 32'(anyB), 32'(vecs[v].expCnt != 0));
            check($sformatf("vec%0d nobypass dataA", v), dataA0, vecs[v].expA0);
            check($sformatf("vec%0d nobypass busy_count", v), 32'(cnt0), 32'(vecs[v].expCnt));
            @(negedge clock);
        end

        // Fill every writable register busy: count must saturate at 31 without wrapping.
        for (int i = 0; i < 32; i++) begin
            drive(mk(0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clock);
        end
        drive(mk(0, 0, 0, 0, 1, 5'd31, 0, 31, 0, 0, 0, 0, 0, 0));
        #2;
        check("all busy count", 32'(cnt), 32'd31);
        check("all busy busyB r31", 32'(busyB), 32'h1);
        check("all busy busyA r0", 32'(busyA), 32'h0);
        check("nobypass busyB r31", 32'(busyB0), 32'h1);
        // Writeback to r31 without bypass keeps busy visible on the non-bypassing instance.
        @(negedge clock);
        drive(mk(0, 1, 5'd31, 32'h31, 0, 0, 31, 31, 0, 0, 0, 0, 0, 0));
        #2;
        check("drain busyB r31 bypass", 32'(busyB), 32'h0);
        check("drain busyB r31 nobypass", 32'(busyB0), 32'h1);
        check("drain dataB r31 nobypass", dataB0, 32'h0);
        @(negedge clock);
        drive(idle);
        ctrl_readRegA = 5'd31;
        #2;
        check("drained count", 32'(cnt), 32'd30);
        check("drained dataA r31", dataA, 32'h31);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
